// File: rtl/rvm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// rvm_mem_arbiter
//
// Shares the single sram port of the rvm platform between two requesters:
// m0 (rvm_core) and m1 (program loader / debug port). Arbitration is
// round-robin, and m0 wins the first tie after reset. An accepted command is
// registered and held on the memory bus until the memory stops stalling. Read
// data and the error flag are then returned to the winner as a one-cycle ack.
//
// Optional feature: define RVM_ARB_TIMEOUT_EN to abort an access that has
// stalled for TIMEOUT_CYCLES cycles. The abort completes with err=1 and rdata=0.
//
// Handshake: mN_req is held together with its command until mN_gnt is seen
// high in the same cycle. gnt is combinational and only occurs in IDLE.
// Completion is signalled by a single-cycle mN_ack, and mN_rdata/mN_err are
// valid only while that ack is high (0 otherwise).
//
// Ports
//   clk, reset                   : clock, async active-high reset
//   mN_req/addr/wdata/ben/wen    : requester N command
//   mN_gnt                       : command accepted this cycle
//   mN_ack/rdata/err             : completion strobe and response
//   mem_cen/addr/wdata/ben/wen   : memory command (registered)
//   mem_rdata/stall/error        : memory response
//   dbg_state                    : current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module rvm_mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_ben,
    input  logic                m0_wen,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_ben,
    input  logic                m1_wen,
    output logic                m0_gnt,
    output logic                m1_gnt,
    output logic                m0_ack,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m0_err,
    output logic                m1_err,
    output logic                mem_cen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_ben,
    output logic                mem_wen,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_stall,
    input  logic                mem_error,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Elaboration-time guard on the timeout range.
    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("rvm_mem_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    state_t                r_state;
    logic                  r_rr_last;
    logic                  r_owner;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_ben;
    logic                  r_wen;
    logic [DATA_W-1:0]     r_rdata;
    logic                  r_err;
`ifdef RVM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_VAL = 16'(TIMEOUT_CYCLES);
    logic [15:0]           r_stall_cnt;
`endif

    logic w_idle;
    logic w_any;
    logic w_pick1;
    logic w_access;
    logic w_resp;

    // Grants are suppressed while reset is held, so that every output is 0 in reset.
    assign w_idle   = (r_state == ST_IDLE) && !reset;
    assign w_any    = m0_req | m1_req;
    // m1 wins when it is alone, or when both request and m0 was served last.
    assign w_pick1  = m1_req && (!m0_req || !r_rr_last);
    assign w_access = (r_state == ST_ACCESS);
    assign w_resp   = (r_state == ST_RESP);

    assign m0_gnt    = w_idle && w_any && !w_pick1;
    assign m1_gnt    = w_idle && w_any && w_pick1;
    assign m0_ack    = w_resp && !r_owner;
    assign m1_ack    = w_resp && r_owner;
    assign m0_rdata  = m0_ack ? r_rdata : '0;
    assign m1_rdata  = m1_ack ? r_rdata : '0;
    assign m0_err    = m0_ack & r_err;
    assign m1_err    = m1_ack & r_err;
    assign mem_cen   = w_access;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_ben   = r_ben;
    assign mem_wen   = r_wen & w_access;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_ben     <= '0;
            r_wen     <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
`ifdef RVM_ARB_TIMEOUT_EN
            r_stall_cnt <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner <= w_pick1;
                        r_addr  <= w_pick1 ? m1_addr  : m0_addr;
                        r_wdata <= w_pick1 ? m1_wdata : m0_wdata;
                        r_ben   <= w_pick1 ? m1_ben   : m0_ben;
                        r_wen   <= w_pick1 ? m1_wen   : m0_wen;
                        r_state <= ST_ACCESS;
`ifdef RVM_ARB_TIMEOUT_EN
                        r_stall_cnt <= '0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (!mem_stall) begin
                        // Captured for writes too; the requester ignores it.
                        r_rdata   <= mem_rdata;
                        r_err     <= mem_error;
                        r_rr_last <= r_owner;
                        r_state   <= ST_RESP;
                    end
`ifdef RVM_ARB_TIMEOUT_EN
                    else if (r_stall_cnt == TO_VAL) begin
                        r_rdata   <= '0;
                        r_err     <= 1'b1;
                        r_rr_last <= r_owner;
                        r_state   <= ST_RESP;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + 16'd1;
                    end
`endif
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Bench for rvm_mem_arbiter. The reference model works on whole transactions.
// At each grant it fixes the stall length, the response data and the ack
// cycle, and from these it predicts every port of the arbiter cycle by cycle.
// ---------------------------------------------------------------------------
module tb_rvm_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int TO = 4;
`ifdef RVM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          m0_req, m1_req, m0_wen, m1_wen;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [BW-1:0] m0_ben, m1_ben;
    logic          m0_gnt, m1_gnt, m0_ack, m1_ack, m0_err, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          mem_cen, mem_wen, mem_stall, mem_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [BW-1:0] mem_ben;
    logic [1:0]    dbg_state;

    rvm_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ben(m0_ben), .m0_wen(m0_wen),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ben(m1_ben), .m1_wen(m1_wen),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_err(m0_err), .m1_err(m1_err),
        .mem_cen(mem_cen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ben(mem_ben),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW+1:0] exp_q[$];   // {owner, err, rdata} of the transaction in flight
    int            obs_q[$];   // observed grant owners

    logic          pend   [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wdata[2];
    logic [BW-1:0] p_ben  [2];
    logic          p_wen  [2];

    logic          in_reset;
    logic          rr_last;
    logic          act_v;
    logic          act_own;
    logic          act_wen;
    int            t_g, t_k, t_ack;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wdata;
    logic [BW-1:0] last_ben;

    bit            rand_mem;
    int            dir_k;
    logic [DW-1:0] dir_rd;
    logic          dir_err;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", tag, cyc, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic post_cmd(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [BW-1:0] b, input logic w);
        pend[id]    = 1'b1;
        p_addr[id]  = a;
        p_wdata[id] = d;
        p_ben[id]   = b;
        p_wen[id]   = w;
    endtask

    // One clock cycle: drive inputs, compare every output with the model, advance.
    task automatic step();
        logic          eg0, eg1, eack, win, acc, timed;
        logic [DW+1:0] pl;
        logic [DW-1:0] erd;
        logic          eerr, er;
        logic [DW-1:0] rd;
        int            idx, k;

        m0_req = pend[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0]; m0_ben = p_ben[0]; m0_wen = p_wen[0];
        m1_req = pend[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1]; m1_ben = p_ben[1]; m1_wen = p_wen[1];
        if (in_reset) begin
            last_addr = '0; last_wdata = '0; last_ben = '0;
        end

        acc = !in_reset && act_v && (cyc > t_g) && (cyc < t_ack);
        idx = cyc - t_g - 1;
        mem_stall = acc ? (idx < t_k) : 1'($urandom_range(0, 1));
        mem_rdata = $urandom();
        mem_error = 1'($urandom_range(0, 1));
        if (acc && idx >= t_k) begin
            pl = exp_q[0];
            mem_rdata = pl[DW-1:0];
            mem_error = pl[DW];
        end

        eg0 = 1'b0; eg1 = 1'b0; win = 1'b0;
        if (!in_reset && !act_v && (pend[0] || pend[1])) begin
            win = pend[1] && (!pend[0] || !rr_last);
            eg0 = !win;
            eg1 = win;
        end
        eack = !in_reset && act_v && (cyc == t_ack);
        erd  = '0; eerr = 1'b0;
        if (eack) begin
            pl   = exp_q[0];
            erd  = pl[DW-1:0];
            eerr = pl[DW];
        end

        #1;
        check("m0_gnt", 64'(m0_gnt), 64'(eg0));
        check("m1_gnt", 64'(m1_gnt), 64'(eg1));
        check("m0_ack", 64'(m0_ack), 64'(eack && !act_own));
        check("m1_ack", 64'(m1_ack), 64'(eack && act_own));
        check("m0_rdata", 64'(m0_rdata), 64'((eack && !act_own) ? erd : '0));
        check("m1_rdata", 64'(m1_rdata), 64'((eack && act_own) ? erd : '0));
        check("m0_err", 64'(m0_err), 64'(eack && !act_own && eerr));
        check("m1_err", 64'(m1_err), 64'(eack && act_own && eerr));
        check("mem_cen", 64'(mem_cen), 64'(acc));
        check("mem_wen", 64'(mem_wen), 64'(acc && act_wen));
        check("mem_addr", 64'(mem_addr), 64'(last_addr));
        check("mem_wdata", 64'(mem_wdata), 64'(last_wdata));
        check("mem_ben", 64'(mem_ben), 64'(last_ben));
        if (in_reset) check("dbg_state_reset", 64'(dbg_state), 64'd0);
        if (m0_gnt) obs_q.push_back(0);
        if (m1_gnt) obs_q.push_back(1);

        if (in_reset) begin
            act_v = 1'b0;
            rr_last = 1'b1;
            exp_q.delete();
        end else if (eack) begin
            pl = exp_q.pop_front();
            rr_last = act_own;
            act_v = 1'b0;
        end else if (eg0 || eg1) begin
            if (rand_mem) begin
                k  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 1));
                rd = $urandom();
                er = ($urandom_range(0, 5) == 0);
            end else begin
                k = dir_k; rd = dir_rd; er = dir_err;
            end
            timed      = TO_EN && (k >= TO + 1);
            act_v      = 1'b1;
            act_own    = win;
            act_wen    = p_wen[win];
            last_addr  = p_addr[win];
            last_wdata = p_wdata[win];
            last_ben   = p_ben[win];
            pend[win]  = 1'b0;
            t_g        = cyc;
            t_k        = k;
            t_ack      = timed ? cyc + TO + 2 : cyc + k + 2;
            exp_q.push_back({win, timed ? 1'b1 : er, timed ? {DW{1'b0}} : rd});
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            p_addr[i] = '0; p_wdata[i] = '0; p_ben[i] = '0; p_wen[i] = 1'b0;
        end
        act_v = 1'b0; act_own = 1'b0; act_wen = 1'b0; rr_last = 1'b1;
        t_g = 0; t_k = 0; t_ack = 0;
        last_addr = '0; last_wdata = '0; last_ben = '0;
        rand_mem = 1'b0; dir_k = 0; dir_rd = '0; dir_err = 1'b0;

        reset = 1'b1; in_reset = 1'b1;
        @(negedge clk);
        run(2);
        reset = 1'b0; in_reset = 1'b0;
        run(1);

        // m0 read, zero stall
        post_cmd(0, 32'h0000_0010, 32'h0, 4'hF, 1'b0);
        dir_k = 0; dir_rd = 32'hDEAD_BEEF; dir_err = 1'b0;
        run(4);

        // m1 write, three stall cycles
        post_cmd(1, 32'h0000_0020, 32'h1234_5678, 4'b0011, 1'b1);
        dir_k = 3; dir_rd = 32'hA5A5_0000; dir_err = 1'b0;
        run(7);

        // m0 read completing with a memory error
        post_cmd(0, 32'h0000_0044, 32'h0, 4'hF, 1'b0);
        dir_k = 1; dir_rd = 32'h0BAD_0BAD; dir_err = 1'b1;
        run(5);

        // reset during ACCESS: transaction dropped, no ack afterwards
        post_cmd(0, 32'h0000_0080, 32'h0, 4'hF, 1'b0);
        dir_k = 3; dir_rd = 32'h1111_2222; dir_err = 1'b0;
        run(2);
        reset = 1'b1; in_reset = 1'b1;
        run(1);
        reset = 1'b0; in_reset = 1'b0;
        run(4);

        // both requesters held from reset: strict alternation
        obs_q.delete();
        dir_k = 0; dir_rd = 32'h5555_AAAA; dir_err = 1'b0;
        for (int c = 0; c < 12; c++) begin
            for (int id = 0; id < 2; id++)
                if (!pend[id]) post_cmd(id, 32'h100 + 32'(c * 4 + id), $urandom(), 4'hF, 1'b0);
            step();
        end
        check("order_count", 64'(obs_q.size() >= 4), 64'd1);
        for (int i = 0; i < 4; i++)
            if (i < obs_q.size()) check("grant_order", 64'(obs_q[i]), 64'(i % 2));
        pend[0] = 1'b0; pend[1] = 1'b0;
        run(4);

`ifdef RVM_ARB_TIMEOUT_EN
        // stall never ends: abort, then the other requester goes next
        post_cmd(0, 32'h0000_0200, 32'h0, 4'hF, 1'b0);
        dir_k = 40; dir_rd = 32'hFFFF_FFFF; dir_err = 1'b0;
        run(1);
        post_cmd(1, 32'h0000_0300, 32'h0, 4'hF, 1'b0);
        post_cmd(0, 32'h0000_0204, 32'h0, 4'hF, 1'b0);
        dir_k = 0;
        run(12);
        pend[0] = 1'b0; pend[1] = 1'b0;
        run(4);
`endif

        // randomized traffic
        rand_mem = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            for (int id = 0; id < 2; id++) begin
                if (!pend[id] && $urandom_range(0, 3) == 0)
                    post_cmd(id, $urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                else if (pend[id] && $urandom_range(0, 19) == 0)
                    pend[id] = 1'b0;
            end
            step();
        end
        for (int i = 0; i < 40 && (act_v || pend[0] || pend[1]); i++) step();
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvm_mem_arbiter.md
# rvm_mem_arbiter

Two-requester arbiter and sequencer for the single shared `sram` memory port of the rvm platform. It lets the `rvm_core` and a second bus master (program loader / debug port) share one memory. It registers each accepted command, holds it on the memory bus until the memory stops stalling, then returns read data and error to the winning requester as a one-cycle acknowledge. Arbitration is round-robin, with requester 0 (the core) favoured out of reset.

## Interface
Parameters:
- `ADDR_W`, 32, address width of both requesters and the memory port.
- `DATA_W`, 32, data width; `DATA_W/8` byte enables.
- `TIMEOUT_CYCLES`, 255, stall cycles tolerated before abort (used only with `RVM_ARB_TIMEOUT_EN`); legal range 1..65535.

Ports (reset is asynchronous and active-high; one clock):
- `clk` in 1: single clock; all state on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_req`/`m1_req` in 1: requester N has a command pending; held with its command until `mN_gnt`.
- `m0_addr`/`m1_addr` in ADDR_W: command address.
- `m0_wdata`/`m1_wdata` in DATA_W: write data.
- `m0_ben`/`m1_ben` in DATA_W/8: byte enables.
- `m0_wen`/`m1_wen` in 1: 1 = write, 0 = read.
- `m0_gnt`/`m1_gnt` out 1: command accepted this cycle; combinational, IDLE only.
- `m0_ack`/`m1_ack` out 1: one-cycle completion strobe.
- `m0_rdata`/`m1_rdata` out DATA_W: read data, valid with ack; 0 otherwise.
- `m0_err`/`m1_err` out 1: error, valid with ack; 0 otherwise.
- `mem_cen` out 1: memory chip enable.
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_ben` out DATA_W/8, `mem_wen` out 1: registered command.
- `mem_rdata` in DATA_W, `mem_stall` in 1, `mem_error` in 1: memory response.

## Operation
- States: IDLE, ACCESS, RESP. Reset -> IDLE, `rr_last` = 1 (so m0 wins the first tie). All outputs 0 in reset.
- IDLE: if exactly one `mN_req`, grant it. If both, grant the requester not equal to `rr_last`. Assert `mN_gnt` the same cycle. Latch addr/wdata/ben/wen and owner id, then -> ACCESS. With no request, stay in IDLE.
- ACCESS: `mem_cen`=1; mem_* driven from latches, stable the whole state. `mem_wen` = latched wen & `mem_cen`. If `mem_stall`=1, stay. If `mem_stall`=0, capture `mem_rdata`/`mem_error` (rdata captured even for writes), `rr_last` <= owner, -> RESP.
- RESP: owner's `mN_ack`=1, with `mN_rdata`/`mN_err` from the capture registers. Non-owner outputs stay 0. -> IDLE unconditionally. No grant in RESP.
- Outside ACCESS: `mem_cen`=0, `mem_wen`=0; `mem_addr`/`mem_wdata`/`mem_ben` hold their last latched values.
- A request deasserted before grant is simply not served. Requests during ACCESS/RESP wait.
- Reset mid-transaction: immediate return to IDLE; the pending transaction is dropped with no ack.

## Timing
- Grant cycle T (IDLE). `mem_cen` rises at T+1. First non-stall cycle S >= T+1. Ack at S+1.
- Zero-stall memory: ack at T+2; next grant at T+3. Peak throughput is 1 transaction per 3 cycles.
- Starvation bound with both requesters continuously requesting: strict alternation, so each waits at most one other transaction.
- `mN_gnt` and `mN_ack` are never both high in the same cycle; at most one gnt and at most one ack per cycle.

## Configuration
- `RVM_ARB_TIMEOUT_EN` defined: a 16-bit stall counter clears on entry to ACCESS and increments on each ACCESS cycle with `mem_stall`=1. When the count equals `TIMEOUT_CYCLES` and `mem_stall` is still 1, the arbiter leaves ACCESS (`mem_cen` drops next cycle) and goes to RESP with err=1, rdata=0. `rr_last` updates as normal.
- Not defined: no counter; ACCESS waits indefinitely for `mem_stall`=0.

## Test plan
- Reset, m0 read 0x0000_0010, memory returns 0xDEAD_BEEF with no stall -> `m0_gnt` at T, `mem_cen` at T+1, `m0_ack`=1 with rdata 0xDEAD_BEEF, err 0, at T+2.
- m1 write 0x1234_5678 to 0x20 with ben 4'b0011, 3 stall cycles -> `mem_wen`=1 and mem_* stable for 4 cycles, `m1_ack` at T+5, m0 outputs 0 throughout.
- Both requesters held high from reset for 4 transactions -> grant order m0, m1, m0, m1.
- `mem_error`=1 on the completing cycle of an m0 read -> `m0_err`=1 for exactly one cycle with the ack.
- `reset` asserted during ACCESS -> same cycle `mem_cen`=0, all outputs 0, no ack afterwards; next request is served normally.
- With `RVM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `mem_stall` held at 1 -> ack with err=1 and rdata=0 at T+6; next grant goes to the other requester if it is pending.
